dmem_wait_bridge: RTL and testbench

//  Sits directly downstream of the core's memory-access stage, between the core DMEM bus and a slow

---
 rtl/dmem_wait_bridge.sv | 112 +++++++++++
 tb/tb_dmem_wait_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_bridge.sv
// Bridges single-cycle core DMEM accesses onto a req/ack memory bus with wait states,
// stalling the core through halt_out and aborting accesses that exceed TIMEOUT cycles.
module dmem_wait_bridge #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic              cpu_read_wrn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              halt_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  input  logic              err_clr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [TW-1:0]       r_timer;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_bus_err;
  logic                w_timeout;

  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      // Clear first so a timeout set later in this block takes priority.
      if (err_clr) begin
        r_bus_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (cpu_valid) begin
            r_mem_we    <= ~cpu_read_wrn;
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
            r_mem_req   <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_timer != TW'(TIMEOUT)) begin
            r_timer <= r_timer + TW'(1);
          end
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_cpu_rdata <= mem_rdata;
            end
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_bus_err <= 1'b1;
            if (!r_mem_we) begin
              r_cpu_rdata <= ERR_DATA;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Launch-cycle halt must be combinational so the core holds on the launch edge.
  assign halt_out  = ((r_state == S_IDLE) && cpu_valid) || (r_state == S_BUSY);
  assign cpu_rdata = r_cpu_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_wait_bridge.sv
// Randomized access-level check of dmem_wait_bridge against a per-transaction reference model
// (latency, load data, sticky error flag, transaction count, reset abort).
module tb_dmem_wait_bridge;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int unsigned N   = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_valid = 1'b0;
  logic          cpu_read_wrn = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          halt_out;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          bus_err;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  dmem_wait_bridge #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TIMEOUT  (TO),
    .ERR_DATA (ERR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_valid    (cpu_valid),
    .cpu_read_wrn (cpu_read_wrn),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .halt_out     (halt_out),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .bus_err      (bus_err),
    .err_clr      (err_clr)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Independent count of bus transactions (rising edges of mem_req)
  int   n_req_rise = 0;
  logic req_d = 1'b0;
  always @(negedge clk) begin
    if (mem_req === 1'b1 && req_d !== 1'b1) n_req_rise++;
    req_d = mem_req;
  end

  // Access descriptors: dl = BUSY cycles the memory waits before acking (>= TO means never)
  bit            rd_a [N];
  logic [AW-1:0] ad_a [N];
  logic [DW-1:0] wd_a [N];
  logic [DW-1:0] rv_a [N];
  int unsigned   dl_a [N];
  bit            cl_a [N];
  bit            b2_a [N];
  bit            ca_a [N];

  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err   = 1'b0;

  task automatic drive_fields(input int i);
    cpu_valid    = 1'b1;
    cpu_read_wrn = rd_a[i];
    cpu_addr     = ad_a[i];
    cpu_wdata    = wd_a[i];
  endtask

  // Entered at a negedge with the DUT in IDLE; leaves at a negedge in IDLE after the access.
  task automatic run_access(input int i);
    int unsigned busy;
    int unsigned exp_busy;
    bit          is_err;
    bit          done;
    int unsigned gap;
    drive_fields(i);
    err_clr = cl_a[i];
    mem_ack = 1'b0;
    #1 chk("halt_launch", halt_out, 1'b1);
    is_err   = (dl_a[i] >= TO);
    exp_busy = is_err ? TO : dl_a[i] + 1;
    busy = 0;
    done = 1'b0;
    for (int k = 0; k < int'(TO) + 4 && !done; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_req) begin
        if (busy == 0) begin
          chk("mem_we", mem_we, !rd_a[i]);
          chk("mem_addr", mem_addr, ad_a[i]);
          chk("mem_wdata", mem_wdata, wd_a[i]);
        end
        chk("halt_busy", halt_out, 1'b1);
        mem_ack   = (busy == dl_a[i]);
        mem_rdata = (busy == dl_a[i]) ? rv_a[i] : $urandom;
        busy++;
      end else begin
        done = 1'b1;
      end
    end
    chk("access_ends", done, 1'b1);
    chk("busy_cycles", busy, exp_busy);
    // Reference outcome of this access
    if (rd_a[i]) exp_rdata = is_err ? ERR : rv_a[i];
    if (is_err) exp_err = 1'b1;
    else if (cl_a[i]) exp_err = 1'b0;
    chk("rdata_done", cpu_rdata, exp_rdata);
    chk("err_done", bus_err, exp_err);
    // DONE cycle: stray ack and (optionally) the next access on the bus must be ignored
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    err_clr   = ca_a[i];
    if (b2_a[i] && i + 1 < int'(N)) drive_fields(i + 1);
    else cpu_valid = 1'b0;
    #1 chk("halt_done", halt_out, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if (ca_a[i]) exp_err = 1'b0;
    chk("no_relaunch", mem_req, 1'b0);
    chk("err_idle", bus_err, exp_err);
    chk("rdata_idle", cpu_rdata, exp_rdata);
    if (!(b2_a[i] && i + 1 < int'(N))) begin
      gap = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gap; g++) begin
        cpu_valid = 1'b0;
        err_clr   = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        #1 chk("halt_gap", halt_out, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("req_gap", mem_req, 1'b0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      rd_a[i] = 1'($urandom_range(0, 1));
      ad_a[i] = AW'($urandom);
      wd_a[i] = $urandom;
      rv_a[i] = $urandom;
      case ($urandom_range(0, 7))
        0:       dl_a[i] = TO - 1;
        1:       dl_a[i] = 20;
        default: dl_a[i] = $urandom_range(0, 5);
      endcase
      cl_a[i] = ($urandom_range(0, 7) == 0);
      b2_a[i] = ($urandom_range(0, 2) == 0);
      ca_a[i] = ($urandom_range(0, 3) == 0);
    end
    rd_a[0] = 1'b1; dl_a[0] = 2; rv_a[0] = 32'h1234_5678; b2_a[0] = 1'b0; cl_a[0] = 1'b0;
    rd_a[1] = 1'b0; ad_a[1] = 16'h0040; wd_a[1] = 32'hCAFE_F00D; dl_a[1] = 0;
    rd_a[2] = 1'b1; dl_a[2] = 100; cl_a[2] = 1'b0; ca_a[2] = 1'b1;
    rd_a[3] = 1'b1; dl_a[3] = TO - 1; cl_a[3] = 1'b0;
    rd_a[4] = 1'b1; dl_a[4] = 50; cl_a[4] = 1'b1; ca_a[4] = 1'b0;
    b2_a[5] = 1'b1; b2_a[6] = 1'b1;
    b2_a[N-2] = 1'b0; b2_a[N-1] = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rdata", cpu_rdata, '0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_halt", halt_out, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < int'(N) - 1; i++) run_access(i);
    chk("req_count", n_req_rise, N - 1);

    // Asynchronous reset in the middle of a BUSY access
    drive_fields(0);
    err_clr = 1'b0;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_req", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    cpu_valid = 1'b0;
    #1;
    chk("async_req", mem_req, 1'b0);
    chk("async_halt", halt_out, 1'b0);
    chk("async_rdata", cpu_rdata, '0);
    chk("async_err", bus_err, 1'b0);
    exp_rdata = '0;
    exp_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("stray_ack_req", mem_req, 1'b0);
      chk("stray_ack_halt", halt_out, 1'b0);
      chk("stray_ack_rdata", cpu_rdata, '0);
    end
    mem_ack = 1'b0;
    run_access(N - 1);
    chk("req_count_final", n_req_rise, N + 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
